// File: rtl/pdm_audio_cic.sv
// PDM microphone front end: PDM clock generation, 3rd-order CIC decimation to
// 16-bit signed PCM, and a valid/ready output stage with sticky overrun.
module pdm_audio_cic #(
  parameter int CLK_DIV        = 6,
  parameter int DECIM_LOG2     = 6,
  parameter int SETTLE_SAMPLES = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  output logic        o_pdm_clk,
  input  logic        i_pdm_data_r,
  output logic [15:0] o_pcm_data,
  output logic        o_pcm_valid,
  input  logic        i_pcm_ready,
  output logic        o_overrun,
  input  logic        i_overrun_clr
);

  localparam int W = 3 * DECIM_LOG2 + 1;
  localparam logic [W-1:0]        MID     = {2'b01, {(W-2){1'b0}}};
  localparam logic signed [W-1:0] PCM_MAX = W'(32767);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t                state;
  logic [7:0]            div_cnt;
  logic [7:0]            settle_cnt;
  logic [DECIM_LOG2-1:0] dec_cnt;
  logic [W-1:0]          int1, int2, int3;
  logic [W-1:0]          cap, dly0, comb1, dly1, comb2, dly2, comb3;
  logic                  cap_v, v1, v2, v3;

  logic                  clear;
  logic                  div_last;
  logic                  strobe;
  logic                  frame_end;
  logic                  deliver;
  logic [W-1:0]          int1_n, int2_n, int3_n;
  logic signed [W-1:0]   s_full, s_shift;
  logic [15:0]           pcm_sat;

  assign clear     = i_reset || !i_enable;
  assign div_last  = (div_cnt == 8'(CLK_DIV - 1));
  // The falling PDM edge is the midpoint of the pad's stable window.
  assign strobe    = div_last && o_pdm_clk;
  assign frame_end = strobe && (dec_cnt == '1);
  assign deliver   = v3 && (state == RUN);

  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    int1_n  = int1 + W'(i_pdm_data_r);
    int2_n  = int2 + int1_n;
    int3_n  = int3 + int2_n;
    s_full  = $signed(comb3 - MID);
    s_shift = s_full >>> (W - 17);
    pcm_sat = (s_shift > PCM_MAX) ? 16'h7fff : s_shift[15:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (clear) begin
      // NOTE: the synchronous clear covers every register, including the comb
      // delay lines, so a restart never leaks a stale partial frame.
      state       <= IDLE;
      div_cnt     <= '0;
      settle_cnt  <= '0;
      dec_cnt     <= '0;
      o_pdm_clk   <= 1'b0;
      int1        <= '0;
      int2        <= '0;
      int3        <= '0;
      cap         <= '0;
      cap_v       <= 1'b0;
      dly0        <= '0;
      comb1       <= '0;
      v1          <= 1'b0;
      dly1        <= '0;
      comb2       <= '0;
      v2          <= 1'b0;
      dly2        <= '0;
      comb3       <= '0;
      v3          <= 1'b0;
      o_pcm_data  <= '0;
      o_pcm_valid <= 1'b0;
    end else begin
      if (div_last) begin
        div_cnt   <= '0;
        o_pdm_clk <= !o_pdm_clk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (strobe) begin
        int1    <= int1_n;
        int2    <= int2_n;
        int3    <= int3_n;
        dec_cnt <= dec_cnt + 1'b1;
      end

      cap_v <= frame_end;
      if (frame_end) cap <= int3_n;

      v1 <= cap_v;
      if (cap_v) begin
        comb1 <= cap - dly0;
        dly0  <= cap;
      end
      v2 <= v1;
      if (v1) begin
        comb2 <= comb1 - dly1;
        dly1  <= comb1;
      end
      v3 <= v2;
      if (v2) begin
        comb3 <= comb2 - dly2;
        dly2  <= comb2;
      end

      case (state)
        IDLE: begin
          settle_cnt <= '0;
          state      <= (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
        end
        SETTLE: begin
          if (v3) begin
            if (settle_cnt == 8'(SETTLE_SAMPLES - 1)) state <= RUN;
            else settle_cnt <= settle_cnt + 8'd1;
          end
        end
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase

      // A landing sample always wins over a same-cycle acceptance.
      if (deliver) begin
        o_pcm_data  <= pcm_sat;
        o_pcm_valid <= 1'b1;
      end else if (o_pcm_valid && i_pcm_ready) begin
        o_pcm_valid <= 1'b0;
      end
    end
  end

  // Overrun survives an enable drop so software can still observe it.
  always_ff @(posedge i_clk) begin
    if (i_reset) o_overrun <= 1'b0;
    else if (!clear && deliver && o_pcm_valid && !i_pcm_ready) o_overrun <= 1'b1;
    else if (i_overrun_clr) o_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_pdm_audio_cic.sv
// Directed bench for pdm_audio_cic at default parameters: clock timing,
// steady-state PCM values for several PDM densities, handshake and resets.
module tb_pdm_audio_cic;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        o_pdm_clk;
  logic        i_pdm_data_r;
  logic [15:0] o_pcm_data;
  logic        o_pcm_valid;
  logic        i_pcm_ready;
  logic        o_overrun;
  logic        i_overrun_clr;

  int vectors     = 0;
  int miscompares = 0;
  int mode        = 1;
  int phase       = 0;

  pdm_audio_cic dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .o_pdm_clk    (o_pdm_clk),
    .i_pdm_data_r (i_pdm_data_r),
    .o_pcm_data   (o_pcm_data),
    .o_pcm_valid  (o_pcm_valid),
    .i_pcm_ready  (i_pcm_ready),
    .o_overrun    (o_overrun),
    .i_overrun_clr(i_overrun_clr)
  );

  always #5 i_clk = ~i_clk;

  // Pad register model: next PDM bit launched on each rising PDM clock.
  // mode 0: all zeros, 1: all ones, 2: alternating, 3: three ones per four.
  always @(posedge o_pdm_clk) begin
    phase = phase + 1;
    case (mode)
      0:       i_pdm_data_r = 1'b0;
      1:       i_pdm_data_r = 1'b1;
      2:       i_pdm_data_r = phase[0];
      default: i_pdm_data_r = (phase[1:0] != 2'd0);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (!o_pcm_valid && n < limit);
    check("wait_valid", {31'd0, o_pcm_valid}, 32'd1);
  endtask

  task automatic get_sample(output logic [15:0] data);
    int n;
    wait_valid(1000, n);
    data = o_pcm_data;
    i_pcm_ready = 1'b1;
    @(posedge i_clk); #1;
    i_pcm_ready = 1'b0;
    check("valid_drop_after_accept", {31'd0, o_pcm_valid}, 32'd0);
  endtask

  initial begin
    int          n, r1, r2;
    logic        prev;
    logic [15:0] d;

    i_reset       = 1'b1;
    i_enable      = 1'b0;
    i_pcm_ready   = 1'b0;
    i_overrun_clr = 1'b0;
    i_pdm_data_r  = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_pdm_clk", {31'd0, o_pdm_clk}, 32'd0);
    check("rst_data", {16'd0, o_pcm_data}, 32'd0);
    check("rst_valid", {31'd0, o_pcm_valid}, 32'd0);
    check("rst_overrun", {31'd0, o_overrun}, 32'd0);

    // All-ones input: clock timing, first-valid latency, positive saturation.
    i_reset  = 1'b0;
    i_enable = 1'b1;
    n = 0; r1 = 0; r2 = 0; prev = 1'b0;
    while (!o_pcm_valid && n < 4000) begin
      @(posedge i_clk); #1;
      n++;
      if (o_pdm_clk && !prev) begin
        if (r1 == 0) r1 = n;
        else if (r2 == 0) r2 = n;
      end
      prev = o_pdm_clk;
    end
    check("first_rise", r1, 32'd6);
    check("pdm_period", r2 - r1, 32'd12);
    check("first_valid_cycle", n, 32'd3076);
    check("ones_saturated", {16'd0, o_pcm_data}, 32'h7fff);

    // Leave it unaccepted: next frame lands 768 cycles later as an overrun.
    repeat (767) @(posedge i_clk);
    #1;
    check("no_overrun_before_frame", {31'd0, o_overrun}, 32'd0);
    @(posedge i_clk); #1;
    check("overrun_set", {31'd0, o_overrun}, 32'd1);
    check("overrun_valid_held", {31'd0, o_pcm_valid}, 32'd1);
    check("overrun_data", {16'd0, o_pcm_data}, 32'h7fff);

    // Enable drop clears the datapath but keeps the sticky flag.
    i_enable = 1'b0;
    @(posedge i_clk); #1;
    check("dis_pdm_clk", {31'd0, o_pdm_clk}, 32'd0);
    check("dis_valid", {31'd0, o_pcm_valid}, 32'd0);
    check("dis_data", {16'd0, o_pcm_data}, 32'd0);
    check("dis_overrun_kept", {31'd0, o_overrun}, 32'd1);
    i_overrun_clr = 1'b1;
    @(posedge i_clk); #1;
    i_overrun_clr = 1'b0;
    check("overrun_cleared", {31'd0, o_overrun}, 32'd0);

    // All-zeros input after restart: settle again, then full-scale negative.
    mode     = 0;
    i_enable = 1'b1;
    wait_valid(4000, n);
    check("restart_valid_cycle", n, 32'd3076);
    check("zeros_min", {16'd0, o_pcm_data}, 32'h8000);
    i_pcm_ready = 1'b1;
    @(posedge i_clk); #1;
    i_pcm_ready = 1'b0;
    check("accept_drops_valid", {31'd0, o_pcm_valid}, 32'd0);

    // Density changes: three outputs to flush the filter, fourth is steady.
    mode = 2;
    repeat (4) get_sample(d);
    check("alternating_zero", {16'd0, d}, 32'h0000);
    mode = 3;
    repeat (4) get_sample(d);
    check("three_quarter", {16'd0, d}, 32'h4000);

    // Acceptance coincident with the next sample landing.
    wait_valid(1000, n);
    repeat (767) @(posedge i_clk);
    #1;
    i_pcm_ready = 1'b1;
    @(posedge i_clk); #1;
    i_pcm_ready = 1'b0;
    check("coincident_valid", {31'd0, o_pcm_valid}, 32'd1);
    check("coincident_no_overrun", {31'd0, o_overrun}, 32'd0);
    check("coincident_data", {16'd0, o_pcm_data}, 32'h4000);
    @(posedge i_clk); #1;
    check("coincident_sample_pending", {31'd0, o_pcm_valid}, 32'd1);

    // Reset mid-frame in RUN, then a full settle before the next sample.
    repeat (300) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    check("midrst_pdm_clk", {31'd0, o_pdm_clk}, 32'd0);
    check("midrst_data", {16'd0, o_pcm_data}, 32'd0);
    check("midrst_valid", {31'd0, o_pcm_valid}, 32'd0);
    check("midrst_overrun", {31'd0, o_overrun}, 32'd0);
    i_reset = 1'b0;
    wait_valid(4000, n);
    check("post_reset_valid_cycle", n, 32'd3076);
    check("post_reset_data", {16'd0, o_pcm_data}, 32'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pdm_audio_cic.md
Name: pdm_audio_cic

Overview:
Downstream consumer of the PDM data pad. It generates the PDM microphone clock from the system clock and samples the pad-registered PDM bit once per PDM clock period. A 3rd-order CIC decimator then converts the 1-bit stream to 16-bit signed PCM. Samples are delivered to the audio FIFO/bus bridge over a valid/ready handshake with sticky overrun reporting.

Parameters:
CLK_DIV, 6, PDM clock half-period in i_clk cycles; legal range 3..255 (6 gives 2 MHz from 24 MHz).
DECIM_LOG2, 6, log2 of decimation ratio R; legal range 6..8 (default R=64).
SETTLE_SAMPLES, 3, decimated outputs discarded after enable/reset.

Ports:
i_clk  input  1  system clock; all logic runs on rising edge
i_reset  input  1  synchronous, active-high reset
i_enable  input  1  run enable; low = PDM clock stopped, filter cleared
o_pdm_clk  output  1  PDM clock to the microphone and to the data pad register clock
i_pdm_data_r  input  1  PDM bit, already registered at the pad on o_pdm_clk rising edge
o_pcm_data  output  16  signed PCM sample
o_pcm_valid  output  1  o_pcm_data holds an undelivered sample
i_pcm_ready  input  1  consumer accepts sample when high with o_pcm_valid
o_overrun  output  1  sticky: a sample was overwritten before acceptance
i_overrun_clr  input  1  one-cycle pulse clears o_overrun

Behaviour:
- Reset (i_reset=1 or i_enable=0): o_pdm_clk=0, o_pcm_data=0, o_pcm_valid=0, all integrators/combs/counters=0, state=IDLE. o_overrun cleared by i_reset only; i_enable=0 preserves it.
- Clock gen: half-period counter 0..CLK_DIV-1; o_pdm_clk toggles when count=CLK_DIV-1. First rise CLK_DIV cycles after enable, period 2*CLK_DIV.
- Sample strobe: asserted for one i_clk on the cycle o_pdm_clk toggles 1->0; i_pdm_data_r sampled only then (pad value stable since rising edge).
- Width W = 3*DECIM_LOG2+1 (19 at default). Input to integrator 1 is 0/1 zero-extended. Three cascaded integrators update on each strobe, mod 2^W wraparound is intentional and correct.
- Decimation counter 0..R-1 advances per strobe; at R-1 the integrator-3 value is captured into the comb section.
- Combs: three differential-delay-1 stages, pipelined one i_clk per stage, mod 2^W. Result C unsigned 0..2^(W-1).
- Conversion: S = C - 2^(W-2) (signed), shift arithmetic right by W-17; saturate +32768 to 32767; lower bound -32768 reachable exactly.
- Latency: converted sample ready 4 i_clk cycles after the strobe completing the frame (CLK_DIV>=3 guarantees pipeline empty before next strobe).
- State machine: IDLE -> SETTLE when i_enable=1 and not reset; SETTLE counts completed frames, discards SETTLE_SAMPLES outputs, then -> RUN; RUN delivers every frame. i_enable low from any state -> IDLE next cycle.
- Handshake: transfer when o_pcm_valid & i_pcm_ready; o_pcm_valid drops next cycle unless a new sample lands the same cycle (then valid stays 1, data updates, no overrun). New sample with o_pcm_valid=1 and i_pcm_ready=0: data replaced, valid stays 1, o_overrun set.
- o_pcm_data stable while o_pcm_valid=1 and not accepted, except on overrun replacement.
- Simultaneous overrun set and i_overrun_clr: set wins.
- Reset mid-frame: partial frame discarded; pipeline contents discarded; SETTLE re-entered on restart.

Test Plan:
- Defaults, i_pdm_data_r=1 constant -> o_pdm_clk period 12 i_clk; first valid at frame 4 (cycle ~3076 after enable); o_pcm_data=32767 (saturated) every frame.
- Constant 0 -> steady o_pcm_data=-32768 (0x8000), no saturation flag needed.
- Alternating 1,0 per strobe -> steady o_pcm_data=0; 3 ones per 4 strobes -> +16384.
- i_pcm_ready held 0 for 3 frames -> o_pcm_valid stays 1, o_overrun=1 after frame 2, data equals newest sample; i_overrun_clr pulse -> o_overrun=0.
- i_pcm_ready=1 coincident with new sample arrival -> valid remains 1, new data, o_overrun stays 0.
- i_reset pulse mid-frame in RUN -> next cycle all outputs 0, o_pdm_clk=0; after release, 3 frames discarded before next valid.
